// File: rtl/audio_scheduler_if.sv
// Control, sound-effect handshake, music ROM and tone-generator signals of the audio scheduler.
interface audio_scheduler_if;
    logic       play;
    logic       loop;
    logic       sfx_req;
    logic [1:0] sfx_id;
    logic       sfx_ack;
    logic [7:0] rom_addr;
    logic [7:0] rom_note;
    logic       rom_end;
    logic [5:0] note;
    logic [1:0] source;
    logic       music_done;

    modport master (
        output play, loop, sfx_req, sfx_id, rom_note, rom_end,
        input  sfx_ack, rom_addr, note, source, music_done
    );

    modport slave (
        input  play, loop, sfx_req, sfx_id, rom_note, rom_end,
        output sfx_ack, rom_addr, note, source, music_done
    );
endinterface

// File: rtl/audio_scheduler.sv
// Music sequencer reading notes from a ROM, with prioritised sound effects that freeze and resume the music.
// IDLE off | FETCH 2-cycle ROM read | PLAY note + duration | SFX 4-step effect | DONE track ended
module audio_scheduler #(
    parameter int NOTE_LEN_LOG2 = 22,
    parameter int SFX_LEN_LOG2  = 20
) (
    input  logic              clk,
    input  logic              reset,
    audio_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_SFX, S_DONE} state_t;

    state_t                   r_state, w_state;
    state_t                   r_saved, w_saved;
    logic                     r_fetch2, w_fetch2;
    logic [NOTE_LEN_LOG2-1:0] r_dur, w_dur;
    logic [1:0]               r_step, w_step;
    logic [SFX_LEN_LOG2-1:0]  r_sfx_cnt, w_sfx_cnt;
    logic [1:0]               r_sfx_id, w_sfx_id;
    logic [5:0]               r_cap, w_cap;
    logic [7:0]               r_addr, w_addr;
    logic [5:0]               r_note, w_note;
    logic [1:0]               r_source, w_source;
    logic                     r_ack, w_ack;
    logic                     r_done, w_done;
    logic                     w_gap;

    function automatic logic [5:0] sfx_note(input logic [1:0] id, input logic [1:0] step);
        logic [5:0] n;
        case ({id, step})
            4'h0: n = 6'd37;  4'h1: n = 6'd41;  4'h2: n = 6'd44;  4'h3: n = 6'd49;
            4'h4: n = 6'd44;  4'h5: n = 6'd49;  4'h6: n = 6'd0;   4'h7: n = 6'd49;
            4'h8: n = 6'd20;  4'h9: n = 6'd17;  4'hA: n = 6'd13;  4'hB: n = 6'd8;
            4'hC: n = 6'd25;  4'hD: n = 6'd20;  4'hE: n = 6'd17;  default: n = 6'd13;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_saved   <= S_IDLE;
            r_fetch2  <= 1'b0;
            r_dur     <= '0;
            r_step    <= '0;
            r_sfx_cnt <= '0;
            r_sfx_id  <= '0;
            r_cap     <= '0;
            r_addr    <= '0;
            r_note    <= '0;
            r_source  <= '0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_saved   <= w_saved;
            r_fetch2  <= w_fetch2;
            r_dur     <= w_dur;
            r_step    <= w_step;
            r_sfx_cnt <= w_sfx_cnt;
            r_sfx_id  <= w_sfx_id;
            r_cap     <= w_cap;
            r_addr    <= w_addr;
            r_note    <= w_note;
            r_source  <= w_source;
            r_ack     <= w_ack;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_saved   = r_saved;
        w_fetch2  = r_fetch2;
        w_dur     = r_dur;
        w_step    = r_step;
        w_sfx_cnt = r_sfx_cnt;
        w_sfx_id  = r_sfx_id;
        w_cap     = r_cap;
        w_addr    = r_addr;
        w_ack     = 1'b0;
        w_done    = 1'b0;

        // An accepted effect freezes the music context; counters simply stop advancing.
        if (bus.sfx_req && r_state != S_SFX) begin
            w_ack     = 1'b1;
            w_saved   = r_state;
            w_state   = S_SFX;
            w_step    = '0;
            w_sfx_cnt = '0;
            w_sfx_id  = bus.sfx_id;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.play) begin
                        w_state  = S_FETCH;
                        w_fetch2 = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!bus.play) begin
                        w_state = S_IDLE;
                    end else if (!r_fetch2) begin
                        w_fetch2 = 1'b1;
                    end else begin
                        w_cap    = bus.rom_note[5:0];
                        w_fetch2 = 1'b0;
                        if (!bus.rom_end) begin
                            w_state = S_PLAY;
                            w_dur   = '0;
                        end else if (bus.loop) begin
                            w_addr = '0;
                        end else begin
                            w_done  = 1'b1;
                            w_addr  = '0;
                            w_state = S_DONE;
                        end
                    end
                end
                S_PLAY: begin
                    if (!bus.play) begin
                        w_state = S_IDLE;
                    end else if (&r_dur) begin
                        w_addr   = r_addr + 8'd1;
                        w_state  = S_FETCH;
                        w_fetch2 = 1'b0;
                    end else begin
                        w_dur = r_dur + 1'b1;
                    end
                end
                S_SFX: begin
                    if (bus.sfx_req && bus.sfx_id > r_sfx_id) begin
                        w_ack     = 1'b1;
                        w_step    = '0;
                        w_sfx_cnt = '0;
                        w_sfx_id  = bus.sfx_id;
                    end else if (&r_sfx_cnt) begin
                        w_sfx_cnt = '0;
                        if (r_step == 2'd3) begin
                            w_state  = r_saved;
                            w_fetch2 = 1'b0;
                        end else begin
                            w_step = r_step + 2'd1;
                        end
                    end else begin
                        w_sfx_cnt = r_sfx_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!bus.play) w_state = S_IDLE;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    // Outputs are derived from the next-state values so the registered copies line up with the state.
    assign w_gap = (w_dur[NOTE_LEN_LOG2-1 -: 4] == 4'd0);

    always_comb begin
        w_note   = '0;
        w_source = 2'd0;
        case (w_state)
            S_FETCH: w_source = 2'd1;
            S_PLAY: begin
                w_source = 2'd1;
                w_note   = w_gap ? 6'd0 : w_cap;
            end
            S_SFX: begin
                w_source = 2'd2;
                w_note   = sfx_note(w_sfx_id, w_step);
            end
            default: ;
        endcase
    end

    assign bus.rom_addr   = r_addr;
    assign bus.note       = r_note;
    assign bus.source     = r_source;
    assign bus.sfx_ack    = r_ack;
    assign bus.music_done = r_done;
endmodule
